// File: rtl/ram_test_pkg.sv
// Shared types for the RAM march tester: sequencer states and pattern modes.
package ram_test_pkg;

    // Sequencer states of the per-address write / read / compare loop.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Data pattern written to (and expected back from) each address.
    typedef enum logic [1:0] {
        MODE_INC      = 2'd0,  // seed + addr, modulo 2^DATA_W
        MODE_WALK1    = 2'd1,  // single one at bit (addr mod DATA_W)
        MODE_INV_ADDR = 2'd2,  // inverted low address bits
        MODE_CONST    = 2'd3   // seed at every address
    } mode_t;

endpackage

// File: rtl/ram_test_pattern.sv
// Combinational pattern generator: maps (mode, seed, addr) to the data word
// written to the RAM and expected back on read. Shared with checker-only blocks.
module ram_test_pattern
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  mode_t             mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

    // Address widened so that both the truncation to DATA_W bits and the
    // modulo by DATA_W stay legal for any ADDR_W / DATA_W combination.
    localparam int EXT_W = ((ADDR_W > 32) ? ADDR_W : 32) + DATA_W;

    logic [EXT_W-1:0]  addr_ext;
    logic [EXT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] addr_low;

    assign addr_ext = EXT_W'(addr);
    assign addr_low = addr_ext[DATA_W-1:0];
    assign bit_idx  = addr_ext % EXT_W'(DATA_W);

    // Select the pattern for the latched mode.
    // NOTE: every output of an always_comb gets a value on every path (the
    // default here, or a case default), otherwise synthesis infers a latch.
    always_comb begin
        pattern = seed;
        case (mode)
            MODE_INC:      pattern = seed + addr_low;
            MODE_WALK1:    pattern = DATA_W'(1) << bit_idx;
            MODE_INV_ADDR: pattern = ~addr_low;
            MODE_CONST:    pattern = seed;
            default:       pattern = seed;
        endcase
    end

endmodule

// File: rtl/ram_march_tester.sv
// RAM self-test sequencer: for every address 0..LAST_ADDR it writes a pattern,
// reads it back RD_LAT cycles later, compares, and accumulates a saturating
// error count plus the first failing address. start/busy/done handshake.
module ram_march_tester
    import ram_test_pkg::*;
#(
    parameter int          ADDR_W    = 17,
    parameter int          DATA_W    = 8,
    parameter int unsigned LAST_ADDR = 2**ADDR_W - 1,
    parameter int          RD_LAT    = 1,   // RAM read latency, must be >= 1
    parameter int          ERR_W     = 16
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_en,
    output logic              ram_r_nw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    // Latency counter holds the number of WAIT cycles still to go minus one,
    // i.e. at most RD_LAT-2.
    localparam int                LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'((RD_LAT > 2) ? RD_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    mode_t             mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] pattern;
    logic              mismatch;
    logic              at_last;

    ram_test_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .mode    (mode_q),
        .seed    (seed_q),
        .addr    (addr),
        .pattern (pattern)
    );

    assign ram_addr = addr;
    assign mismatch = (ram_rdata != pattern);
    assign at_last  = (addr == LAST);

    // State register; rst is synchronous and wins over everything else.
    // NOTE: clocked state is always assigned with <= so that every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge dclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs of the sequencer.
    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_r_nw  = 1'b1;
        ram_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                ram_en    = 1'b1;
                ram_r_nw  = 1'b0;
                ram_wdata = pattern;
                state_nxt = READ;
            end
            READ: begin
                busy      = 1'b1;
                ram_en    = 1'b1;
                state_nxt = (RD_LAT == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (lat_cnt == '0) state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = at_last ? DONE : WRITE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: latched configuration, address, latency counter and
    // error bookkeeping. Results hold from DONE until the next accepted start.
    always_ff @(posedge dclk) begin
        if (rst) begin
            addr           <= '0;
            mode_q         <= MODE_INC;
            seed_q         <= '0;
            lat_cnt        <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr           <= '0;
                        mode_q         <= mode_t'(mode);
                        seed_q         <= seed;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                    end
                end
                READ: lat_cnt <= LAT_INIT;
                WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
                CHECK: begin
                    if (mismatch) begin
                        if (err_cnt == '0) first_err_addr <= addr;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                    end
                    // pass is settled here so that it is already valid in DONE
                    if (at_last) begin
                        pass <= !mismatch && (err_cnt == '0);
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_march_tester.sv
// Testbench for ram_march_tester: four DUT configurations, each with its own
// RAM model (optional read-data fault mask, RD_LAT-deep read pipeline).
// A reference model pushes expected writes and sweep results into per-config
// queues; per-config monitors pop and compare whenever the DUT writes or
// pulses done.
module tb_ram_march_tester;

    localparam int NCFG = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;

    // cfg0: ideal RAM, 4 addresses        cfg1: data bit 3 stuck at 0, 16 addresses
    // cfg2: ideal RAM, RD_LAT 3, 2 addrs  cfg3: RAM reads 0x00, ERR_W 2, 8 addresses
    localparam int CFG_LAST [NCFG] = '{3, 15, 1, 7};
    localparam int CFG_LAT  [NCFG] = '{1, 1, 3, 1};
    localparam int CFG_ERRW [NCFG] = '{16, 16, 16, 2};
    localparam int CFG_MASK [NCFG] = '{8'hFF, 8'hF7, 8'hFF, 8'h00};

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int cyc;
        int errs;
        int first;
        int pass;
    } res_t;

    logic          dclk = 1'b0;
    logic          rst;
    logic          start_a     [NCFG];
    logic [1:0]    mode_a      [NCFG];
    logic [DW-1:0] seed_a      [NCFG];
    logic          ram_en_a    [NCFG];
    logic          ram_r_nw_a  [NCFG];
    logic [AW-1:0] ram_addr_a  [NCFG];
    logic [DW-1:0] ram_wdata_a [NCFG];
    logic [DW-1:0] ram_rdata_a [NCFG];
    logic          busy_a      [NCFG];
    logic          done_a      [NCFG];
    logic          pass_a      [NCFG];
    logic [15:0]   err_a       [NCFG];
    logic [AW-1:0] first_a     [NCFG];

    wr_t wq [NCFG][$];
    res_t rq [NCFG][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 dclk = ~dclk;

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pattern rules written directly from the mode definitions.
    function automatic int pattern_of(input int mode, input int seed, input int a);
        case (mode)
            0:       return (seed + a) % 256;
            1:       return 1 << (a % DW);
            2:       return (~a) & 255;
            default: return seed;
        endcase
    endfunction

    // Reference model for one sweep: expected write stream and final result.
    task automatic expect_sweep(input int g, input int mode, input int seed,
                                input int start_cyc, output res_t r);
        int emax;
        int p;
        emax    = (1 << CFG_ERRW[g]) - 1;
        r.cyc   = start_cyc + (CFG_LAST[g] + 1) * (2 + CFG_LAT[g]) + 1;
        r.errs  = 0;
        r.first = 0;
        r.pass  = 1;
        for (int a = 0; a <= CFG_LAST[g]; a++) begin
            p = pattern_of(mode, seed, a);
            wq[g].push_back('{addr: a, data: p});
            if ((p & CFG_MASK[g]) != p) begin
                if (r.pass == 1) r.first = a;
                r.pass = 0;
                if (r.errs < emax) r.errs++;
            end
        end
        rq[g].push_back(r);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int            EW   = CFG_ERRW[g];
        localparam int            LAT  = CFG_LAT[g];
        localparam logic [DW-1:0] MASK = DW'(CFG_MASK[g]);

        logic [EW-1:0] err;
        logic [DW-1:0] mem  [2**AW];
        logic [DW-1:0] pipe [LAT];

        ram_march_tester #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .LAST_ADDR (CFG_LAST[g]),
            .RD_LAT    (LAT),
            .ERR_W     (EW)
        ) dut (
            .dclk           (dclk),
            .rst            (rst),
            .start          (start_a[g]),
            .mode           (mode_a[g]),
            .seed           (seed_a[g]),
            .ram_en         (ram_en_a[g]),
            .ram_r_nw       (ram_r_nw_a[g]),
            .ram_addr       (ram_addr_a[g]),
            .ram_wdata      (ram_wdata_a[g]),
            .ram_rdata      (ram_rdata_a[g]),
            .busy           (busy_a[g]),
            .done           (done_a[g]),
            .pass           (pass_a[g]),
            .err_cnt        (err),
            .first_err_addr (first_a[g])
        );

        assign err_a[g]       = 16'(err);
        assign ram_rdata_a[g] = pipe[LAT-1];

        // RAM model. Outside a read the pipeline is fed data that differs from
        // the expected word, so a compare taken a cycle early or late fails.
        always @(posedge dclk) begin
            if (ram_en_a[g] && !ram_r_nw_a[g]) mem[ram_addr_a[g]] <= ram_wdata_a[g];
            if (ram_en_a[g] && ram_r_nw_a[g])  pipe[0] <= mem[ram_addr_a[g]] & MASK;
            else if (ram_en_a[g])              pipe[0] <= ~ram_wdata_a[g];
            else                               pipe[0] <= ~(mem[ram_addr_a[g]] & MASK);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        // Monitor: compare every RAM write and every done pulse with the model.
        always @(negedge dclk) begin : mon
            wr_t  w;
            res_t r;
            if (ram_en_a[g] && !ram_r_nw_a[g]) begin
                check($sformatf("cfg%0d write_expected", g), 32'(wq[g].size() > 0), 1);
                if (wq[g].size() > 0) begin
                    w = wq[g].pop_front();
                    check($sformatf("cfg%0d wr_addr", g), 32'(ram_addr_a[g]), w.addr);
                    check($sformatf("cfg%0d wr_data@%0d", g, w.addr), 32'(ram_wdata_a[g]), w.data);
                end
            end
            if (done_a[g]) begin
                check($sformatf("cfg%0d done_expected", g), 32'(rq[g].size() > 0), 1);
                if (rq[g].size() > 0) begin
                    r = rq[g].pop_front();
                    check($sformatf("cfg%0d done_cycle", g), 32'(cyc), r.cyc);
                    check($sformatf("cfg%0d err_cnt", g), 32'(err_a[g]), r.errs);
                    check($sformatf("cfg%0d first_err_addr", g), 32'(first_a[g]), r.first);
                    check($sformatf("cfg%0d pass", g), 32'(pass_a[g]), r.pass);
                    check($sformatf("cfg%0d busy_in_done", g), 32'(busy_a[g]), 0);
                end
            end
        end
    end

    task automatic wait_done(input int g, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge dclk);
            seen = done_a[g];
        end
        check($sformatf("cfg%0d done_within_budget", g), 32'(seen), 1);
    endtask

    // One full sweep; optionally pulses start mid-sweep. start is also pulsed
    // in the DONE cycle, which must not launch another sweep.
    task automatic run_sweep(input int g, input int mode, input int seed, input bit poke);
        res_t r;
        bit   seen;
        @(negedge dclk);
        start_a[g] = 1'b1;
        mode_a[g]  = 2'(mode);
        seed_a[g]  = 8'(seed);
        expect_sweep(g, mode, seed, cyc, r);
        @(negedge dclk);
        start_a[g] = 1'b0;
        mode_a[g]  = 2'($urandom);
        seed_a[g]  = 8'($urandom);
        if (poke) begin
            repeat (3) @(negedge dclk);
            start_a[g] = 1'b1;
            @(negedge dclk);
            start_a[g] = 1'b0;
        end
        wait_done(g, seen);
        if (seen) begin
            start_a[g] = 1'b1;
            @(negedge dclk);
            start_a[g] = 1'b0;
            repeat (2) @(negedge dclk);
            check($sformatf("cfg%0d idle_after_done", g), 32'(busy_a[g]), 0);
            check($sformatf("cfg%0d hold_err_cnt", g), 32'(err_a[g]), r.errs);
            check($sformatf("cfg%0d hold_first_err", g), 32'(first_a[g]), r.first);
            check($sformatf("cfg%0d hold_pass", g), 32'(pass_a[g]), r.pass);
        end
    endtask

    initial begin
        res_t r;
        bit   seen;

        // Reset held for two cycles with start asserted everywhere.
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            start_a[g] = 1'b1;
            mode_a[g]  = 2'($urandom);
            seed_a[g]  = 8'($urandom);
        end
        repeat (2) @(posedge dclk);
        @(negedge dclk);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("cfg%0d rst busy", g), 32'(busy_a[g]), 0);
            check($sformatf("cfg%0d rst done", g), 32'(done_a[g]), 0);
            check($sformatf("cfg%0d rst pass", g), 32'(pass_a[g]), 0);
            check($sformatf("cfg%0d rst err_cnt", g), 32'(err_a[g]), 0);
            check($sformatf("cfg%0d rst first_err", g), 32'(first_a[g]), 0);
            check($sformatf("cfg%0d rst ram_en", g), 32'(ram_en_a[g]), 0);
            check($sformatf("cfg%0d rst ram_r_nw", g), 32'(ram_r_nw_a[g]), 1);
            check($sformatf("cfg%0d rst ram_addr", g), 32'(ram_addr_a[g]), 0);
            check($sformatf("cfg%0d rst ram_wdata", g), 32'(ram_wdata_a[g]), 0);
        end
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) start_a[g] = 1'b0;

        // Directed sweeps.
        run_sweep(0, 0, 8'h01, 1'b0);
        run_sweep(1, 1, int'($urandom_range(255, 0)), 1'b0);
        run_sweep(2, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)), 1'b0);
        run_sweep(3, 3, 8'hA5, 1'b0);

        // Randomised sweeps, some with start pulsed while busy.
        for (int g = 0; g < NCFG; g++) begin
            repeat (3) begin
                run_sweep(g, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
                          1'($urandom_range(1, 0)));
            end
        end

        // Reset in the READ cycle of address 2 on the always-failing RAM.
        @(negedge dclk);
        start_a[3] = 1'b1;
        mode_a[3]  = 2'd3;
        seed_a[3]  = 8'h5A;
        expect_sweep(3, 3, 8'h5A, cyc, r);
        @(negedge dclk);
        start_a[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge dclk);
            seen = ram_en_a[3] && ram_r_nw_a[3] && (ram_addr_a[3] == 4'd2);
        end
        check("cfg3 reached_read_addr2", 32'(seen), 1);
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            wq[g].delete();
            rq[g].delete();
        end
        @(negedge dclk);
        check("cfg3 midrst busy", 32'(busy_a[3]), 0);
        check("cfg3 midrst ram_en", 32'(ram_en_a[3]), 0);
        check("cfg3 midrst err_cnt", 32'(err_a[3]), 0);
        check("cfg3 midrst ram_addr", 32'(ram_addr_a[3]), 0);
        rst = 1'b0;
        run_sweep(3, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)), 1'b1);

        repeat (3) @(negedge dclk);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("cfg%0d writes_drained", g), 32'(wq[g].size()), 0);
            check($sformatf("cfg%0d results_drained", g), 32'(rq[g].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_march_tester.md
Name: ram_march_tester

Overview:
- Parametrised RAM self-test sequencer on the divided clock domain.
- Per address: write a mode-selected pattern, read it back after a configurable read latency, compare.
- Counts mismatches and records the first failing address; start/busy/done handshake.
- Sits between a board-level test controller (buttons/LEDs) and the single-port ram instance.

Parameters:
- ADDR_W, 17, RAM address width.
- DATA_W, 8, RAM data width.
- LAST_ADDR, 2**ADDR_W-1, final address tested; sweep is 0..LAST_ADDR.
- RD_LAT, 1, RAM read latency in dclk cycles; must be >= 1.
- ERR_W, 16, error counter width.

Ports:
- dclk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- mode  in  2  pattern: 0 = seed+addr, 1 = walking one, 2 = ~addr[DATA_W-1:0], 3 = constant seed.
- seed  in  DATA_W  pattern seed; latched with start.
- ram_en  out  1  RAM enable.
- ram_r_nw  out  1  1 = read, 0 = write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  write data to RAM.
- ram_rdata  in  DATA_W  read data from RAM.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last sweep had zero errors; held until next start.
- err_cnt  out  ERR_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Reset: rst is synchronous, active-high; clock is dclk. Every output is 0 (ram_r_nw = 1) and the state is IDLE. rst overrides start and any in-flight sweep.
- IDLE:
  - busy = 0, ram_en = 0.
  - On start = 1: latch mode and seed, set addr = 0, clear err_cnt, first_err_addr and pass; go to WRITE.
- WRITE (1 cycle): ram_en = 1, ram_r_nw = 0, ram_addr = addr, ram_wdata = pattern(addr); go to READ.
- READ (1 cycle): ram_en = 1, ram_r_nw = 1, ram_addr = addr. If RD_LAT = 1 go to CHECK, else go to WAIT.
- WAIT (RD_LAT-1 cycles): ram_en = 0, counted by a latency counter.
- CHECK (1 cycle):
  - Sample ram_rdata exactly RD_LAT cycles after the READ cycle and compare it with pattern(addr).
  - On mismatch: if err_cnt = 0, set first_err_addr = addr; increment err_cnt, saturating.
  - If addr = LAST_ADDR go to DONE, else addr + 1 and go to WRITE.
- DONE (1 cycle): done = 1, pass = (err_cnt == 0 including this last check), busy = 0; then IDLE.
- busy is 1 in WRITE, READ, WAIT and CHECK.
- Cost is 2 + RD_LAT cycles per address. done is high in cycle (LAST_ADDR+1)*(2+RD_LAT)+1 counted from the start-sampling edge.
- Patterns:
  - Mode 0 uses modulo-2^DATA_W add of seed and addr truncated.
  - Mode 1 is 1 << (addr mod DATA_W).
  - Patterns are computed from the latched mode and seed; changes on mode/seed while busy have no effect.
- start asserted while busy or in DONE is ignored, with no queuing.
- addr never exceeds LAST_ADDR and never wraps past it.
- err_cnt, first_err_addr and pass hold after DONE until the next accepted start.

Decomposition:
- Shared package ram_test_pkg holds:
  - state encoding constants (IDLE, WRITE, READ, WAIT, CHECK, DONE);
  - mode constants (MODE_INC, MODE_WALK1, MODE_INV_ADDR, MODE_CONST).
- One combinational sub-module, ram_test_pattern (inputs mode, seed, addr; output pattern), shared with a future checker-only block.
- Sequencer FSM, latency counter and error logic stay in ram_march_tester.

Test Plan:
- Reset: drive rst for 2 cycles with start = 1 -> all outputs 0, ram_r_nw = 1, busy = 0, no RAM write issued.
- Ideal RAM model, RD_LAT = 1, LAST_ADDR = 3, mode 0, seed 0x01 -> writes 01,02,03,04 to addr 0..3; done pulses in cycle 13 after start; pass = 1, err_cnt = 0.
- RAM model with data bit 3 stuck at 0, mode 1, DATA_W = 8, LAST_ADDR = 15 -> failures at addr 3 and 11; err_cnt = 2, first_err_addr = 3, pass = 0.
- RD_LAT = 3, model returning data 3 cycles after read, LAST_ADDR = 1 -> 5 cycles per address, done in cycle 11, pass = 1. Sampling one cycle early or late must fail.
- Reset mid-sweep: assert rst in the READ cycle of addr 2 -> next cycle busy = 0, ram_en = 0, err_cnt = 0; a new start restarts at addr 0. start pulsed while busy leaves the sweep unchanged.
- ERR_W = 2, RAM returning 0x00 always, mode 3, seed 0xA5, LAST_ADDR = 7 -> err_cnt saturates at 3, first_err_addr = 0, pass = 0.
